rom_addr_sequencer: RTL and testbench
=====================================

// Module: rom_addr_sequencer
// PURPOSE
//  Upstream address generator for the 128x1 LUT-tree ROM. Steps a 7-bit
//  address from a start to an end address at a programmable rate and drives
//  the ROM address pins. Samples the ROM's combinational 1-bit output once
//  per step and presents it as a registered bit stream with a valid strobe.
//  Sits between control logic (buttons/host) and the ROM.
// PARAMETERS
//  AW     7   address width; ROM depth = 2**AW
//  DIV_W  16  width of the step-rate divider input
// PORTS
//  CLKIN      in   1      system clock
//  RESETN     in   1      asynchronous active-low reset
//  start      in   1      1-cycle request: begin sequence (accepted in IDLE only)
//  stop       in   1      abort sequence, return to IDLE
//  first_addr in   AW     first address of sequence
//  last_addr  in   AW     last address of sequence (inclusive)
//  div        in   DIV_W  cycles per step; 0 is treated as 1
//  addr       out  AW     ROM address (to ROM J1)
//  rom_data   in   1      ROM data bit (from ROM D0), combinational on addr
//  bit_out    out  1      registered sample of rom_data
//  bit_valid  out  1      1-cycle strobe: bit_out updated this cycle
//  busy       out  1      high in RUN
//  done       out  1      1-cycle strobe: sequence completed normally
// BEHAVIOUR
//  Reset: state=IDLE, addr=0, bit_out=0, bit_valid=0, busy=0, done=0,
//   prescaler=0. Reset is asynchronous and overrides everything, including
//   mid-sequence.
//  States: IDLE, RUN.
//  IDLE: start=1 and stop=0 -> addr<=first_addr, prescaler<=0, state<=RUN.
//   first_addr/last_addr/div are captured at this edge. Later changes are
//   ignored until the next start. addr holds its last value while in IDLE.
//  RUN: busy=1. Prescaler counts 0..D-1, where D = max(div,1). The cycle
//   with prescaler==D-1 is a tick:
//   - bit_out<=rom_data (value at current addr); bit_valid=1 next cycle.
//   - If addr==last_addr: done=1 next cycle, state<=IDLE.
//   - Else addr<=addr+1 mod 2**AW, prescaler<=0.
//   First sample is therefore D cycles after start is accepted. Each address
//   is held D cycles. N = ((last-first) mod 2**AW)+1 bits are emitted.
//  Wrap: first_addr>last_addr wraps 127->0 and continues to last_addr.
//   first==last emits exactly 1 bit.
//  stop in RUN: state<=IDLE next edge; no bit_valid or done that cycle.
//   stop has priority over a coincident tick.
//  start while RUN is ignored. start+stop together in IDLE: stop wins, stay
//   IDLE.
//  bit_valid and done are never high for more than one cycle per event.
//   On the last bit, done and bit_valid assert in the same cycle.
// CONFIGURATION
//  ROM_SEQ_LOOP_EN defined: on the last-address tick the sequencer does not
//   finish. addr<=first_addr (captured), done pulses each pass, busy stays
//   high, and the sequence repeats until stop.
//  ROM_SEQ_LOOP_EN undefined: single pass, as above. No loop logic is
//   synthesised.
// TESTING
//  1 reset: RESETN=0 -> all outputs 0, state IDLE. Release; idle 10 cycles
//    -> no strobes.
//  2 first=3, last=6, div=2, start -> addr 3,4,5,6 each held 2 cycles;
//    4 bit_valid strobes 2 cycles apart. bit_out equals ROM[3..6]; done with
//    the 4th strobe; busy low next cycle.
//  3 wrap: first=126, last=1, div=0 -> addr 126,127,0,1 on consecutive
//    cycles; 4 strobes; done.
//  4 stop on the same cycle as the 2nd tick (first=0, last=9, div=3) ->
//    exactly 1 strobe, no done, IDLE next cycle. start during RUN is ignored.
//  5 RESETN low mid-sequence -> outputs 0 immediately (asynchronous). A new
//    start afterwards runs a clean sequence.
//  6 ROM_SEQ_LOOP_EN: first=10, last=11, div=1 -> addr 10,11,10,11,...;
//    done every 2 strobes; stop ends the sequence. Without the macro: a
//    single pass.

Source files
------------

// File: rtl/rom_addr_sequencer.sv
// Steps a ROM address from a captured first to last address at a programmable rate
// and samples the ROM output once per step. Define ROM_SEQ_LOOP_EN to repeat passes until stop.
module rom_addr_sequencer #(
    parameter int AW    = 7,
    parameter int DIV_W = 16
) (
    input  logic             CLKIN,
    input  logic             RESETN,
    input  logic             start,
    input  logic             stop,
    input  logic [AW-1:0]    first_addr,
    input  logic [AW-1:0]    last_addr,
    input  logic [DIV_W-1:0] div,
    output logic [AW-1:0]    addr,
    input  logic             rom_data,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    last_q, last_d;
    logic [DIV_W-1:0] dm1_q, dm1_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             bit_q, bit_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             tick_s;
`ifdef ROM_SEQ_LOOP_EN
    logic [AW-1:0]    first_q, first_d;
`endif

    // dm1 holds max(div,1)-1, so a tick is simply presc_q reaching it
    assign tick_s = (presc_q == dm1_q);

    // Next-state logic: capture in IDLE, step/sample on ticks in RUN
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        dm1_d   = dm1_q;
        presc_d = presc_q;
        bit_d   = bit_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
`ifdef ROM_SEQ_LOOP_EN
        first_d = first_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    addr_d  = first_addr;
                    last_d  = last_addr;
                    dm1_d   = (div == DIV_ZERO) ? DIV_ZERO : (div - DIV_ONE);
                    presc_d = DIV_ZERO;
`ifdef ROM_SEQ_LOOP_EN
                    first_d = first_addr;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // stop beats a coincident tick: no sample, no strobe
                if (stop) begin
                    state_d = IDLE;
                end else if (tick_s) begin
                    bit_d   = rom_data;
                    valid_d = 1'b1;
                    presc_d = DIV_ZERO;
                    if (addr_q == last_q) begin
                        done_d = 1'b1;
`ifdef ROM_SEQ_LOOP_EN
                        addr_d = first_q;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end else begin
                    presc_d = presc_q + DIV_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            addr_q  <= {AW{1'b0}};
            last_q  <= {AW{1'b0}};
            dm1_q   <= DIV_ZERO;
            presc_q <= DIV_ZERO;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef ROM_SEQ_LOOP_EN
            first_q <= {AW{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            dm1_q   <= dm1_d;
            presc_q <= presc_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef ROM_SEQ_LOOP_EN
            first_q <= first_d;
`endif
        end
    end

    assign addr      = addr_q;
    assign bit_out   = bit_q;
    assign bit_valid = valid_q;
    assign done      = done_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_rom_addr_sequencer.sv
// Directed self-checking bench for rom_addr_sequencer with a behavioural 128x1 ROM.
module tb_rom_addr_sequencer;

    logic        CLKIN;
    logic        RESETN;
    logic        start;
    logic        stop;
    logic [6:0]  first_addr;
    logic [6:0]  last_addr;
    logic [15:0] div;
    logic [6:0]  addr;
    logic        rom_data;
    logic        bit_out;
    logic        bit_valid;
    logic        busy;
    logic        done;

    logic [127:0] rom_tbl;
    int n_checks;
    int n_fail;

    rom_addr_sequencer #(.AW(7), .DIV_W(16)) dut (
        .CLKIN(CLKIN), .RESETN(RESETN), .start(start), .stop(stop),
        .first_addr(first_addr), .last_addr(last_addr), .div(div),
        .addr(addr), .rom_data(rom_data), .bit_out(bit_out),
        .bit_valid(bit_valid), .busy(busy), .done(done)
    );

    assign rom_data = rom_tbl[addr];

    initial CLKIN = 1'b0;
    always #5 CLKIN = ~CLKIN;

    task automatic cyc();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic launch(input logic [6:0] f, input logic [6:0] l, input logic [15:0] d);
        first_addr = f; last_addr = l; div = d; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        #3;
        n_checks++;
        if ({addr, bit_out, bit_valid, busy, done} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%0d bit=%b v=%b busy=%b done=%b, want all 0",
                     addr, bit_out, bit_valid, busy, done);
        end
        cyc();
        RESETN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            n_checks++;
            if ({bit_valid, done, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_idle k=%0d: got v=%b done=%b busy=%b, want 000", k, bit_valid, done, busy);
            end
        end
    endtask

    task automatic test_basic();
        logic [6:0] ea;
        launch(7'd3, 7'd6, 16'd2);
        n_checks++;
        if (addr !== 7'd3 || busy !== 1'b1 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_start: got addr=%0d busy=%b v=%b, want 3 1 0", addr, busy, bit_valid);
        end
        // first/last/div changes after capture must be ignored
        first_addr = 7'd90; last_addr = 7'd91; div = 16'd7;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            ea = (k >= 6) ? 7'd6 : 7'(3 + k / 2);
            n_checks++;
            if (addr !== ea || bit_valid !== (k % 2 == 0 && k <= 8) ||
                done !== (k == 8) || busy !== (k < 8)) begin
                n_fail++;
                $display("FAIL basic_step k=%0d: got addr=%0d v=%b done=%b busy=%b, want addr=%0d v=%b done=%b busy=%b",
                         k, addr, bit_valid, done, busy, ea, (k % 2 == 0 && k <= 8), (k == 8), (k < 8));
            end
            if (k % 2 == 0 && k <= 8) begin
                n_checks++;
                if (bit_out !== rom_tbl[2 + k / 2]) begin
                    n_fail++;
                    $display("FAIL basic_bit k=%0d: got %b want %b", k, bit_out, rom_tbl[2 + k / 2]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [6:0] ea;
        logic [6:0] sa;
        launch(7'd126, 7'd1, 16'd0);
        n_checks++;
        if (addr !== 7'd126) begin
            n_fail++;
            $display("FAIL wrap_start: got addr=%0d want 126", addr);
        end
        for (int k = 1; k <= 5; k++) begin
            cyc();
            ea = 7'(126 + ((k > 3) ? 3 : k));
            sa = 7'(126 + k - 1);
            n_checks++;
            if (addr !== ea || bit_valid !== (k <= 4) || done !== (k == 4) || busy !== (k < 4)) begin
                n_fail++;
                $display("FAIL wrap_step k=%0d: got addr=%0d v=%b done=%b busy=%b, want addr=%0d v=%b done=%b busy=%b",
                         k, addr, bit_valid, done, busy, ea, (k <= 4), (k == 4), (k < 4));
            end
            if (k <= 4) begin
                n_checks++;
                if (bit_out !== rom_tbl[sa]) begin
                    n_fail++;
                    $display("FAIL wrap_bit k=%0d: got %b want %b", k, bit_out, rom_tbl[sa]);
                end
            end
        end
    endtask

    task automatic test_stop();
        int strobes;
        strobes = 0;
        launch(7'd0, 7'd9, 16'd3);
        // start during RUN with new parameters must be ignored
        first_addr = 7'd50; last_addr = 7'd50; start = 1'b1;
        cyc();
        start = 1'b0;
        n_checks++;
        if (addr !== 7'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_restart_ignored: got addr=%0d busy=%b want 0 1", addr, busy);
        end
        for (int k = 2; k <= 5; k++) begin
            cyc();
            if (bit_valid === 1'b1) strobes++;
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_checks++;
        if (strobes !== 1 || bit_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || addr !== 7'd1) begin
            n_fail++;
            $display("FAIL stop_tick: got strobes=%0d v=%b done=%b busy=%b addr=%0d, want 1 0 0 0 1",
                     strobes, bit_valid, done, busy, addr);
        end
        start = 1'b1; stop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_checks++;
            if ({bit_valid, done, busy} !== 3'b000 || addr !== 7'd1) begin
                n_fail++;
                $display("FAIL stop_idle k=%0d: got v=%b done=%b busy=%b addr=%0d, want 0 0 0 1",
                         k, bit_valid, done, busy, addr);
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_async_reset();
        launch(7'd20, 7'd30, 16'd1);
        cyc(); cyc(); cyc();
        #2;
        RESETN = 1'b0;
        #1;
        n_checks++;
        if ({addr, bit_out, bit_valid, busy, done} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset: got addr=%0d bit=%b v=%b busy=%b done=%b, want all 0",
                     addr, bit_out, bit_valid, busy, done);
        end
        cyc();
        RESETN = 1'b1;
        cyc();
        launch(7'd40, 7'd41, 16'd1);
        cyc();
        n_checks++;
        if (bit_valid !== 1'b1 || bit_out !== rom_tbl[40] || addr !== 7'd41 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_1: got v=%b bit=%b addr=%0d done=%b, want 1 %b 41 0",
                     bit_valid, bit_out, addr, done, rom_tbl[40]);
        end
        cyc();
        n_checks++;
        if (bit_valid !== 1'b1 || bit_out !== rom_tbl[41] || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_2: got v=%b bit=%b done=%b busy=%b, want 1 %b 1 0",
                     bit_valid, bit_out, done, busy, rom_tbl[41]);
        end
    endtask

    task automatic test_loop();
        launch(7'd10, 7'd11, 16'd1);
`ifdef ROM_SEQ_LOOP_EN
        for (int k = 1; k <= 6; k++) begin
            cyc();
            n_checks++;
            if (bit_valid !== 1'b1 || bit_out !== rom_tbl[(k % 2 == 1) ? 10 : 11] ||
                addr !== ((k % 2 == 1) ? 7'd11 : 7'd10) || done !== (k % 2 == 0) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL loop_step k=%0d: got v=%b bit=%b addr=%0d done=%b busy=%b",
                         k, bit_valid, bit_out, addr, done, busy);
            end
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || bit_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_stop: got busy=%b v=%b done=%b, want 000", busy, bit_valid, done);
        end
`else
        cyc(); cyc();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bit_out !== rom_tbl[11]) begin
            n_fail++;
            $display("FAIL single_pass_done: got done=%b busy=%b bit=%b, want 1 0 %b", done, busy, bit_out, rom_tbl[11]);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_checks++;
            if ({bit_valid, done, busy} !== 3'b000 || addr !== 7'd11) begin
                n_fail++;
                $display("FAIL single_pass_idle k=%0d: got v=%b done=%b busy=%b addr=%0d", k, bit_valid, done, busy, addr);
            end
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rom_tbl  = 128'h9A3C_55F0_1E2D_C3B4_7768_0F1E_A5D2_3C96;
        start = 1'b0; stop = 1'b0;
        first_addr = 7'd0; last_addr = 7'd0; div = 16'd0;
        #1;
        test_reset();
        test_basic();
        test_wrap();
        test_stop();
        test_async_reset();
        test_loop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
